// File: rtl/instqueue.sv
`default_nettype none
// ============================================================================
// Module   : instqueue
// Purpose  : Instruction queue between the fetcher and the decoder. It is a
//            circular FIFO of {instruction word, PC} pairs. The oldest entry is
//            presented to the combinational decoder every cycle. The head
//            advances only when dispatch accepts the decoded instruction. A ROB
//            flush drains the queue completely, and back-pressure is applied to
//            the fetcher while the queue is full.
//
// Ports    : clk_in               - clock, all state updates on the rising edge
//            rst_in               - asynchronous reset, active low
//            rdy_in               - global ready; while low all state holds
//            rob_flush_in         - misprediction flush, empties the queue
//            fetcher_en_in        - fetcher presents a valid instruction
//            fetcher_inst_in[31:0]- instruction word to enqueue
//            fetcher_pc_in[31:0]  - PC of that instruction
//            instqueue_full_out   - queue holds DEPTH entries, do not push
//            dispatcher_stall_in  - downstream cannot accept, hold the head
//            decoder_inst_en_out  - head entry is valid (queue non-empty)
//            decoder_inst_out     - head instruction word, 0 when empty
//            decoder_pc_out       - head PC, 0 when empty
//
// Revision : 1.0 - initial release
// ============================================================================
module instqueue #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_flush_in,
  input  logic        fetcher_en_in,
  input  logic [31:0] fetcher_inst_in,
  input  logic [31:0] fetcher_pc_in,
  output logic        instqueue_full_out,
  input  logic        dispatcher_stall_in,
  output logic        decoder_inst_en_out,
  output logic [31:0] decoder_inst_out,
  output logic [31:0] decoder_pc_out
);

  localparam int                  c_DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_COUNT_FULL = c_DEPTH[DEPTH_LOG2:0];

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]           r_inst_mem [c_DEPTH];
  logic [31:0]           r_pc_mem   [c_DEPTH];
  logic [DEPTH_LOG2-1:0] r_head;
  logic [DEPTH_LOG2-1:0] r_tail;
  // One bit wider than the pointers so that full (DEPTH) and empty (0) are
  // distinguishable even though head == tail in both cases.
  logic [DEPTH_LOG2:0]   r_count;

  // --------------------------------------------------------------------------
  // Derived control
  // --------------------------------------------------------------------------
  logic w_empty;
  logic w_full;
  logic w_flush;
  logic w_push;
  logic w_pop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_COUNT_FULL);

  // Flush has priority over any same-cycle push or pop; rdy_in low freezes
  // everything, including the flush itself.
  assign w_flush = rdy_in && rob_flush_in;
  assign w_push  = rdy_in && !rob_flush_in && fetcher_en_in && !w_full;
  assign w_pop   = rdy_in && !rob_flush_in && !w_empty && !dispatcher_stall_in;

  // --------------------------------------------------------------------------
  // Storage: not reset. Entries beyond the live window are unreachable, so
  // their contents after reset or flush are irrelevant.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_inst_mem[r_tail] <= fetcher_inst_in;
      r_pc_mem[r_tail]   <= fetcher_pc_in;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      // Pointers wrap modulo DEPTH through natural overflow.
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: functions of registered state only. The head data is masked to
  // zero when empty so stale storage never leaks to the decoder.
  // --------------------------------------------------------------------------
  assign instqueue_full_out  = w_full;
  assign decoder_inst_en_out = !w_empty;
  assign decoder_inst_out    = w_empty ? 32'd0 : r_inst_mem[r_head];
  assign decoder_pc_out      = w_empty ? 32'd0 : r_pc_mem[r_head];

endmodule
`default_nettype wire

// File: doc/instqueue.md
# instqueue

Instruction queue between the fetcher and the decoder: a circular FIFO that buffers fetched instruction words with their PCs and presents the oldest entry to the combinational decoder each cycle. It sequences the decoder by advancing the head only when the dispatch stage accepts the decoded instruction. It drains completely on a ROB flush and applies back-pressure to the fetcher when full.

## Interface
- `DEPTH_LOG2`, default 4: log2 of entry count. DEPTH = 2^DEPTH_LOG2 = 16 entries.
- `clk_in`  input  1  clock; all state updates on the rising edge.
- `rst_in`  input  1  asynchronous, active-low reset (low = reset).
- `rdy_in`  input  1  global ready; while low, all state holds.
- `rob_flush_in`  input  1  misprediction flush from the ROB.
- `fetcher_en_in`  input  1  fetcher presents a valid instruction this cycle.
- `fetcher_inst_in`  input  32  instruction word.
- `fetcher_pc_in`  input  32  PC of that instruction.
- `instqueue_full_out`  output  1  queue holds DEPTH entries; the fetcher must not push.
- `dispatcher_stall_in`  input  1  RS, LSB or ROB cannot accept; the head must not advance.
- `decoder_inst_en_out`  output  1  head entry valid (queue non-empty).
- `decoder_inst_out`  output  32  head instruction word; 0 when empty.
- `decoder_pc_out`  output  32  head PC; 0 when empty.

## Operation
- State:
  - storage array of DEPTH × {inst[31:0], pc[31:0]};
  - head and tail pointers, DEPTH_LOG2 bits each; they wrap modulo DEPTH naturally;
  - count, DEPTH_LOG2+1 bits, range 0..DEPTH.
- Derived signals:
  - empty = (count == 0);
  - `instqueue_full_out` = (count == DEPTH);
  - `decoder_inst_en_out` = !empty.
- Output sourcing:
  - All outputs depend on registered state only, never combinationally on inputs.
  - When empty, `decoder_inst_out` and `decoder_pc_out` are forced to 0.
- push = `rdy_in` && !`rob_flush_in` && `fetcher_en_in` && !full.
  - Writes storage[tail] and increments tail.
  - A push attempted while full is silently dropped, and state is unchanged by it.
- pop = `rdy_in` && !`rob_flush_in` && !empty && !`dispatcher_stall_in`. Increments head.
- count update:
  - push only: count + 1;
  - pop only: count − 1;
  - both or neither: count unchanged.
  - Simultaneous push and pop is legal in every state except full (no push) and empty (no pop).
- Flush (`rdy_in` && `rob_flush_in`):
  - head = tail = count = 0;
  - any same-cycle push or pop is discarded.
  - Storage contents are not cleared; they are unreachable.
- `rdy_in` low: no push, no pop, no flush. All state and outputs hold.
- Reset (`rst_in` low, asynchronous, at any time including mid-push or mid-flush):
  - head = tail = count = 0;
  - `decoder_inst_en_out` = 0, `decoder_inst_out` = 0, `decoder_pc_out` = 0, `instqueue_full_out` = 0.
  - Storage need not be reset.

## Timing
- Push-to-present latency is 1 cycle. An instruction pushed into an empty queue at edge N appears on `decoder_*_out` with `decoder_inst_en_out` = 1 during cycle N+1.
- Pop takes effect at the edge. The next entry (or the empty state) is visible in the following cycle.
- Throughput: one push and one pop per cycle sustained. The queue never bubbles when it is non-empty and unstalled.
- `instqueue_full_out` rises the cycle after the push that makes count = DEPTH. It falls the cycle after the first pop from full.
- Flush asserted in cycle N empties the queue: `decoder_inst_en_out` = 0 in cycle N+1. The first post-flush push is accepted in cycle N+1.
- Reset deassertion: the first push is accepted on the first rising edge with `rst_in` high and `rdy_in` high.

## Test plan
- Push three entries, {0x00500093, pc 0x0}, {0x00a00113, pc 0x4}, {0x002081b3, pc 0x8}, with `dispatcher_stall_in` = 0.
  - Outputs present each entry one cycle after its push, in order.
  - `decoder_inst_en_out` drops the cycle after the last pop.
- Hold `dispatcher_stall_in` = 1 and push 17 instructions.
  - `instqueue_full_out` = 1 after the 16th push.
  - The 17th is dropped and count stays 16.
  - Release the stall: the 16 entries are popped in order, PCs 0x0 to 0x3C.
  - `instqueue_full_out` clears one cycle after the first pop.
- Wrap-around: at count = 15 with head = 3, push and pop every cycle for 40 cycles.
  - count stays 15 throughout.
  - PCs emerge strictly sequential across the pointer wrap.
- Assert `rob_flush_in` for one cycle while count = 7 and `fetcher_en_in` = 1.
  - Next cycle: `decoder_inst_en_out` = 0 and count = 0.
  - A push of pc 0x100 in the following cycle is presented one cycle later.
- Hold `rdy_in` = 0 for 5 cycles with pushes, unstalled dispatch and a flush pulse.
  - No state or output change occurs.
- Pull `rst_in` low asynchronously between edges at count = 9.
  - All outputs are 0 immediately.
  - After release, the first push appears one cycle later.
